// File: rtl/dlock_code_tx.sv
// Serial code transmitter for the digital-lock link: shifts a fixed code out MSB first,
// optionally repeating it with idle gap cycles between frames.
module dlock_code_tx #(
  parameter int unsigned           CODE_LEN   = 6,
  parameter logic [CODE_LEN-1:0]   CODE       = CODE_LEN'(6'b110100),
  parameter int unsigned           GAP_CYCLES = 2,
  parameter logic                  IDLE_BIT   = 1'b0
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       start,
  input  logic [3:0] reps,
  input  logic       abort,
  output logic       d_out,
  output logic       d_valid,
  output logic       busy,
  output logic       done
);

  localparam int unsigned BIT_W = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
  localparam int unsigned GAP_W = 4;
  localparam int unsigned FRM_W = 4;

  localparam logic [BIT_W-1:0] BIT_TOP = BIT_W'(CODE_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_TOP = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [BIT_W-1:0]   r_bit_idx;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic [FRM_W-1:0]   r_frames;
  logic               r_d_out;
  logic               r_d_valid;
  logic               r_busy;
  logic               r_done;

  logic [BIT_W-1:0]   w_next_idx;
  logic [FRM_W-1:0]   w_frames_left;

  assign w_next_idx    = r_bit_idx - BIT_W'(1);
  assign w_frames_left = r_frames - FRM_W'(1);

  // Sequencer: state, counters and registered outputs advance together
  always_ff @(posedge clk) begin
    if (clear) begin
      r_state   <= S_IDLE;
      r_bit_idx <= '0;
      r_gap_cnt <= '0;
      r_frames  <= '0;
      r_d_out   <= IDLE_BIT;
      r_d_valid <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !abort) begin
            r_frames  <= (reps == 4'd0) ? FRM_W'(1) : reps;
            r_bit_idx <= BIT_TOP;
            r_d_out   <= CODE[CODE_LEN-1];
            r_d_valid <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= S_SEND;
          end
        end

        S_SEND: begin
          if (abort) begin
            r_d_out   <= IDLE_BIT;
            r_d_valid <= 1'b0;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end else if (r_bit_idx != '0) begin
            r_bit_idx <= w_next_idx;
            r_d_out   <= CODE[w_next_idx];
          end else begin
            r_frames <= w_frames_left;
            if (w_frames_left == '0) begin
              r_d_out   <= IDLE_BIT;
              r_d_valid <= 1'b0;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
              r_state   <= S_DONE;
            end else if (GAP_CYCLES > 0) begin
              r_gap_cnt <= GAP_TOP;
              r_d_out   <= IDLE_BIT;
              r_d_valid <= 1'b0;
              r_state   <= S_GAP;
            end else begin
              // back-to-back frames: restart the code with no bubble
              r_bit_idx <= BIT_TOP;
              r_d_out   <= CODE[CODE_LEN-1];
            end
          end
        end

        S_GAP: begin
          if (abort) begin
            r_d_out   <= IDLE_BIT;
            r_d_valid <= 1'b0;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end else if (r_gap_cnt == '0) begin
            r_bit_idx <= BIT_TOP;
            r_d_out   <= CODE[CODE_LEN-1];
            r_d_valid <= 1'b1;
            r_state   <= S_SEND;
          end else begin
            r_gap_cnt <= r_gap_cnt - GAP_W'(1);
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_d_out   <= IDLE_BIT;
          r_d_valid <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign d_out   = r_d_out;
  assign d_valid = r_d_valid;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_dlock_code_tx.sv
// Bench for dlock_code_tx: directed scenarios plus random traffic against a
// frame-queue reference model of the expected output stream.
module tb_dlock_code_tx;

  localparam int unsigned CODE_LEN = 6;
  localparam int unsigned GAP      = 2;

  logic       clk = 1'b0;
  logic       clear, start, abort;
  logic [3:0] reps;
  logic       d_out, d_valid, busy, done;

  logic       start0, abort0;
  logic [3:0] reps0;
  logic       d_out0, d_valid0, busy0, done0;

  int n_chk = 0;
  int n_err = 0;

  logic [5:0] code_v = 6'b110100;
  // expected outputs packed as {d_out, d_valid, busy, done}
  logic [3:0] q[$];
  logic [3:0] cur = 4'b0000;

  int         busy_cnt, done_cnt, match_cnt;
  logic [5:0] hist;

  always #5 clk = ~clk;

  dlock_code_tx dut (
    .clk(clk), .clear(clear), .start(start), .reps(reps), .abort(abort),
    .d_out(d_out), .d_valid(d_valid), .busy(busy), .done(done)
  );

  dlock_code_tx #(.GAP_CYCLES(0)) dut_nogap (
    .clk(clk), .clear(clear), .start(start0), .reps(reps0), .abort(abort0),
    .d_out(d_out0), .d_valid(d_valid0), .busy(busy0), .done(done0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Queue up the whole transmission: frames of code bits, gaps between, then done
  task automatic build(input logic [3:0] r);
    int n;
    n = (r == 4'd0) ? 1 : int'(r);
    for (int f = 0; f < n; f++) begin
      for (int i = CODE_LEN - 1; i >= 0; i--) q.push_back({code_v[i], 3'b110});
      if (f < n - 1)
        for (int g = 0; g < int'(GAP); g++) q.push_back(4'b0010);
    end
    q.push_back(4'b0001);
  endtask

  task automatic model_step(input logic c, input logic s, input logic [3:0] r, input logic a);
    if (c) begin
      q.delete();
      cur = 4'b0000;
    end else if (cur[1] && a) begin
      q.delete();
      cur = 4'b0000;
    end else if (q.size() > 0) begin
      cur = q.pop_front();
    end else if (cur[0]) begin
      cur = 4'b0000;
    end else if (s && !a) begin
      build(r);
      cur = q.pop_front();
    end else begin
      cur = 4'b0000;
    end
  endtask

  task automatic cycle(input logic c, input logic s, input logic [3:0] r, input logic a,
                       input string tag);
    clear = c; start = s; reps = r; abort = a;
    model_step(c, s, r, a);
    @(posedge clk);
    #1;
    chk(tag, 32'({d_out, d_valid, busy, done}), 32'(cur));
    busy_cnt += int'(busy);
    done_cnt += int'(done);
    hist = {hist[4:0], d_out};
    if (hist == 6'b110100) match_cnt++;
  endtask

  task automatic reset_counts();
    busy_cnt = 0; done_cnt = 0; match_cnt = 0; hist = '0;
  endtask

  initial begin
    logic [11:0] bits0;
    int          vcnt, first_v, last_v, d0cnt;

    clear = 1'b1; start = 1'b0; abort = 1'b0; reps = 4'd0;
    start0 = 1'b0; abort0 = 1'b0; reps0 = 4'd2;
    reset_counts();

    cycle(1, 0, 0, 0, "reset");
    cycle(1, 0, 0, 0, "reset");

    // single frame
    reset_counts();
    cycle(0, 1, 4'd1, 0, "t1");
    repeat (8) cycle(0, 0, 0, 0, "t1");
    chk("t1_busy", 32'(busy_cnt), 32'd6);
    chk("t1_done", 32'(done_cnt), 32'd1);

    // three frames with gaps
    reset_counts();
    cycle(0, 1, 4'd3, 0, "t2");
    repeat (25) cycle(0, 0, 0, 0, "t2");
    chk("t2_busy", 32'(busy_cnt), 32'd22);
    chk("t2_done", 32'(done_cnt), 32'd1);
    chk("t2_match", 32'(match_cnt), 32'd3);

    // reps=0 behaves as one frame
    reset_counts();
    cycle(0, 1, 4'd0, 0, "t3");
    repeat (8) cycle(0, 0, 0, 0, "t3");
    chk("t3_busy", 32'(busy_cnt), 32'd6);
    chk("t3_done", 32'(done_cnt), 32'd1);

    // start/reps noise while busy is ignored
    reset_counts();
    cycle(0, 1, 4'd2, 0, "t4");
    repeat (15) cycle(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 0, "t4");
    repeat (3) cycle(0, 0, 0, 0, "t4");
    chk("t4_busy", 32'(busy_cnt), 32'd14);
    chk("t4_done", 32'(done_cnt), 32'd1);

    // start held high restarts after one idle cycle
    reset_counts();
    repeat (16) cycle(0, 1, 4'd1, 0, "t4h");
    repeat (3) cycle(0, 0, 0, 0, "t4h");
    chk("t4h_busy", 32'(busy_cnt), 32'd12);
    chk("t4h_done", 32'(done_cnt), 32'd2);

    // abort on the third bit
    reset_counts();
    cycle(0, 1, 4'd3, 0, "t5a");
    repeat (2) cycle(0, 0, 0, 0, "t5a");
    cycle(0, 0, 0, 1, "t5a");
    chk("t5a_busy", 32'(busy), 32'd0);
    repeat (10) cycle(0, 0, 0, 0, "t5a");
    chk("t5a_done", 32'(done_cnt), 32'd0);

    // clear in the middle of a gap
    cycle(0, 1, 4'd2, 0, "t5c");
    repeat (6) cycle(0, 0, 0, 0, "t5c");
    chk("t5c_gap", 32'({d_valid, busy}), 32'b01);
    cycle(1, 0, 0, 0, "t5c");
    chk("t5c_out", 32'({d_out, d_valid, busy, done}), 32'd0);

    // loopback: one detector hit per frame
    reset_counts();
    cycle(0, 1, 4'd2, 0, "t6");
    repeat (18) cycle(0, 0, 0, 0, "t6");
    chk("t6_match", 32'(match_cnt), 32'd2);

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      cycle(1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 3) == 0),
            4'($urandom_range(0, 5)), 1'($urandom_range(0, 49) == 0), "rand");
    end

    // gapless instance: two frames back to back
    cycle(1, 0, 0, 0, "g0_clr");
    bits0 = '0; vcnt = 0; first_v = -1; last_v = -1; d0cnt = 0;
    start0 = 1'b1;
    for (int k = 0; k < 16; k++) begin
      cycle(0, 0, 0, 0, "g0_main");
      start0 = 1'b0;
      if (d_valid0) begin
        bits0 = {bits0[10:0], d_out0};
        vcnt++;
        if (first_v < 0) first_v = k;
        last_v = k;
      end
      d0cnt += int'(done0);
    end
    chk("g0_bits", 32'(bits0), 32'h000_0D34);
    chk("g0_vcnt", 32'(vcnt), 32'd12);
    chk("g0_span", 32'(last_v - first_v + 1), 32'd12);
    chk("g0_done", 32'(d0cnt), 32'd1);
    chk("g0_idle", 32'({d_out0, d_valid0, busy0}), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
